fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
- Instruction prefetch unit that sits directly upstream of the fetch stage.
- Issues sequential word requests to a variable-latency instruction memory and buffers the returned instructions, each with its PC, in a small FIFO.
- Presents instructions to the fetch stage through a valid/ready handshake.
- Flushes and restarts at a new PC when the pipeline redirects on a jump or branch.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 3, width of occupancy count; equals clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  request to instruction memory; held high until acknowledged.
- imem_addr  out  32  word-aligned request address; stable while imem_req is high.
- imem_ack  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- redirect  in  1  one-cycle pulse from decode/execute: flush and restart.
- redirect_pc  in  32  new fetch address; sampled when redirect=1.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  fetch stage consumes the head this cycle.
- inst_out  out  32  instruction at queue head.
- inst_pc  out  32  PC of inst_out.
- count  out  CNT_W  current queue occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, queue empty, count=0.
  - imem_req=0, inst_valid=0.
  - imem_addr=RESET_PC; inst_out and inst_pc are 0.
  - Any in-flight request is abandoned. The memory must tolerate imem_req dropping during reset.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: live request outstanding.
  - STALE: request outstanding whose data will be discarded.
  - imem_req=1 in REQ and STALE. imem_addr=req_pc (registered).
- Slot accounting:
  - free = DEPTH - count - (state==REQ ? 1 : 0).
  - A new request is issued only if free > 0 after this cycle's push and pop are applied.
- IDLE transitions:
  - If free>0 and no redirect: go to REQ next edge, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- REQ transitions:
  - On imem_ack: push {imem_rdata, req_pc} into the queue.
  - If space remains after the push/pop, stay in REQ with req_pc<=fetch_pc, fetch_pc+=4. This gives zero-bubble back-to-back requests.
  - Otherwise go to IDLE.
- STALE transitions:
  - On imem_ack: discard the data, then go to REQ with req_pc<=fetch_pc, fetch_pc+=4.
  - Without imem_ack: remain in STALE.
- Redirect has highest priority:
  - Queue cleared (count=0 next cycle). Any pop or push in the same cycle is ignored.
  - fetch_pc<=redirect_pc.
  - From IDLE: go to IDLE. Request issue starts the following cycle.
  - From REQ or STALE without imem_ack: go to STALE, because the outstanding request cannot be withdrawn.
  - From REQ or STALE with imem_ack that same cycle: data discarded, go to IDLE.
  - Redirect arriving while in STALE: updates fetch_pc and stays in STALE (or goes to IDLE if acked).
- Output handshake:
  - inst_valid = (count != 0). inst_out and inst_pc are driven from the head entry combinationally.
  - Pop occurs when inst_valid && inst_ready && !redirect.
  - inst_ready while empty has no effect.
- Latency:
  - The queue write happens on the ack edge, so inst_valid rises the next cycle.
  - First request is asserted on the cycle after reset release. With an immediate ack, the first inst_valid appears 2 cycles after reset release.
- Full queue:
  - Simultaneous push and pop keep count unchanged.
  - Push never overflows, because slot reservation prevents it.
  - A pop while full in IDLE allows a new request the next cycle.
- Pointers and PC:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - fetch_pc increments modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
  - Bits [1:0] of redirect_pc are forced to 0.

Test Plan:
- Reset, imem_ack tied 1, inst_ready=0 -> requests at 0,4,8,C on consecutive cycles; then imem_req=0, count=4, inst_pc=0; no fifth request.
- Ack tied 1, inst_ready=1 continuously -> steady one instruction per cycle; inst_pc sequence 0,4,8,... with no gaps after the first valid.
- Ack 3 cycles after req -> imem_addr held stable across the 3 wait cycles; each instruction is visible one cycle after its ack.
- Redirect to 0x100 while a request for 0x10 is pending, ack 2 cycles later -> data for 0x10 discarded; count=0; next imem_addr=0x100; first inst_pc=0x100.
- Redirect with imem_ack and inst_ready all high in the same cycle -> queue empty next cycle, no pop counted, state IDLE, then a request issued for redirect_pc.
- Redirect to 0xFFFF_FFF8 with ack tied 1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0, 4; rst pulsed low mid-wait -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue sitting in front of the fetch stage.
// Streams sequential word requests to a variable-latency instruction memory,
// buffers {instruction, pc} pairs in a small FIFO and hands them to fetch
// through a valid/ready handshake. A redirect flushes the queue and restarts
// fetching at the new PC; a request already on the bus when the redirect
// arrives is allowed to complete, and its data is dropped.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_out,
  output logic [31:0]      inst_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [31:0]        fetch_pc_r;
  logic [31:0]        req_pc_r;
  logic               imem_req_r;
  logic [31:0]        data_mem_r [DEPTH];
  logic [31:0]        pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic               space_s;
  logic [CNT_W-1:0]   count_next_s;

  // Handshake qualifiers and post-push/pop occupancy; a redirect cancels both.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (!redirect) begin
      pop_s  = (count_r != {CNT_W{1'b0}}) && inst_ready;
      push_s = (state_r == REQ) && imem_ack;
    end else begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end
    // Outstanding live request is folded in via push_s only once it lands,
    // so "space" here means a slot is still free after this cycle settles.
    count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    space_s      = (count_next_s < DEPTH_CNT);
  end

  // Next-state selection; issue_s marks cycles that launch a new request.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          state_next_s = IDLE;
        end else if (space_s) begin
          state_next_s = REQ;
          issue_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (redirect) begin
          state_next_s = imem_ack ? IDLE : STALE;
        end else if (imem_ack) begin
          if (space_s) begin
            state_next_s = REQ;
            issue_s      = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = REQ;
        end
      end
      STALE: begin
        if (redirect) begin
          state_next_s = imem_ack ? IDLE : STALE;
        end else if (imem_ack) begin
          state_next_s = REQ;
          issue_s      = 1'b1;
        end else begin
          state_next_s = STALE;
        end
      end
      default: begin
        state_next_s = IDLE;
        issue_s      = 1'b0;
      end
    endcase
  end

  // Request FSM: state, registered request strobe and the fetch/request PCs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      imem_req_r <= 1'b0;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
    end else begin
      state_r    <= state_next_s;
      imem_req_r <= (state_next_s != IDLE);
      if (redirect) begin
        fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      end else if (issue_s) begin
        req_pc_r   <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  // Queue bookkeeping: pointers wrap naturally at DEPTH, redirect empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Queue storage: returned word and the PC it was fetched from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = req_pc_r;
  assign inst_valid = (count_r != {CNT_W{1'b0}});
  assign inst_out   = data_mem_r[rd_ptr_r];
  assign inst_pc    = pc_mem_r[rd_ptr_r];
  assign count      = count_r;

endmodule
